decode_queue: RTL and testbench

- Registered, parametrised successor to the combinational RV32I control decoder.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and decodes each into an rv32i_control_word plus a monitor_t record.
- Queues decoded entries in a BUF_DEPTH-entry FIFO toward the execute stage.
- Adds flush, trap-halt sequencing and a retirement order counter for the RVFI-style monitor.

---
 rtl/decode_queue_if.sv | 61 ++++++
 rtl/decode_queue.sv | 132 +++++++++++++
 tb/tb_decode_queue.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// decode_queue_if: decoded-entry types plus the fetch/execute handshake bundle of decode_queue
package decode_queue_pkg;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SLL = 3'd1, ALU_SRA = 3'd2, ALU_SUB = 3'd3,
    ALU_XOR = 3'd4, ALU_SRL = 3'd5, ALU_OR = 3'd6, ALU_AND = 3'd7;
  localparam logic [2:0] CMP_BLT = 3'b100, CMP_BLTU = 3'b110;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_ALU_OUT = 2'd1, PC_ALU_MOD2 = 2'd2;
  localparam logic A1_RS1 = 1'b0, A1_PC = 1'b1;
  localparam logic [2:0] A2_I_IMM = 3'd0, A2_U_IMM = 3'd1, A2_B_IMM = 3'd2, A2_S_IMM = 3'd3,
    A2_J_IMM = 3'd4, A2_RS2 = 3'd5;
  localparam logic CMP_RS2 = 1'b0, CMP_I_IMM = 1'b1;
  localparam logic [3:0] RF_ALU_OUT = 4'd0, RF_BR_EN = 4'd1, RF_U_IMM = 4'd2, RF_LW = 4'd3,
    RF_PC_PLUS4 = 4'd4, RF_LB = 4'd5, RF_LBU = 4'd6, RF_LH = 4'd7, RF_LHU = 4'd8;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       load_regfile;
    logic       br;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pcmux_sel;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic       cmpmux_sel;
    logic [3:0] regfilemux_sel;
    logic       trap;
  } rv32i_control_word;
  typedef struct packed {
    logic        commit;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } monitor_t;
endpackage

interface decode_queue_if #(parameter int XLEN = 32, parameter int ORDER_W = 64);
  import decode_queue_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  rv32i_control_word out_word;
  monitor_t          out_monitor;
  logic [ORDER_W-1:0] out_order;
  logic              flush;
  logic              halted;
  modport master(output in_valid, in_instr, in_pc, out_ready, flush,
                 input in_ready, out_valid, out_word, out_monitor, out_order, halted);
  modport slave(input in_valid, in_instr, in_pc, out_ready, flush,
                output in_ready, out_valid, out_word, out_monitor, out_order, halted);
endinterface

// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode into a BUF_DEPTH FIFO with flush, trap halt and retire order; RV32M_EN makes op_reg funct7=0x01 legal
module decode_queue import decode_queue_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int ORDER_W   = 64
) (
  input logic           clk,
  input logic           rst,
  decode_queue_if.slave bus
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
`ifdef RV32M_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif
  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_queue: XLEN must be 32");
  end
  if (BUF_DEPTH < 1 || BUF_DEPTH > 8) begin : g_depth_chk
    $error("decode_queue: BUF_DEPTH must be 1..8");
  end
  typedef enum logic {RUN, HALT} state_t;
  typedef struct packed {
    rv32i_control_word word;
    monitor_t          mon;
  } entry_t;
  state_t            state, state_n;
  entry_t            mem [BUF_DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [ORDER_W-1:0] order;
  rv32i_control_word w;
  monitor_t          m;
  logic [6:0]        op, f7;
  logic [2:0]        f3;
  logic              shift, slt, mext, push, pop;
  assign op = bus.in_instr[6:0];
  assign f3 = bus.in_instr[14:12];
  assign f7 = bus.in_instr[31:25];
  assign shift = f3 == 3'd1 || f3 == 3'd5;
  assign slt = f3 == 3'd2 || f3 == 3'd3;
  assign mext = op == OP_REG && f7 == 7'h01;
  always_comb begin
    w = '0;
    w.opcode = op;
    w.rd = bus.in_instr[11:7];
    w.funct3 = f3;
    w.funct7 = f7;
    w.aluop = f3;
    case (op)
      OP_LUI: begin w.load_regfile = 1'b1; w.regfilemux_sel = RF_U_IMM; end
      OP_AUIPC: begin
        w.load_regfile = 1'b1; w.alumux1_sel = A1_PC; w.alumux2_sel = A2_U_IMM; w.aluop = ALU_ADD;
      end
      OP_JAL: begin
        w.load_regfile = 1'b1; w.regfilemux_sel = RF_PC_PLUS4; w.alumux1_sel = A1_PC;
        w.alumux2_sel = A2_J_IMM; w.aluop = ALU_ADD; w.pcmux_sel = PC_ALU_OUT;
      end
      OP_JALR: begin
        w.load_regfile = 1'b1; w.regfilemux_sel = RF_PC_PLUS4; w.alumux2_sel = A2_I_IMM;
        w.aluop = ALU_ADD; w.pcmux_sel = PC_ALU_MOD2;
      end
      OP_BR: begin
        w.br = 1'b1; w.cmpop = f3; w.alumux1_sel = A1_PC; w.alumux2_sel = A2_B_IMM; w.aluop = ALU_ADD;
        w.trap = f3 == 3'd2 || f3 == 3'd3;
      end
      OP_LOAD: begin
        w.load_regfile = 1'b1; w.mem_read = 1'b1; w.alumux2_sel = A2_I_IMM; w.aluop = ALU_ADD;
        w.regfilemux_sel = f3 == 3'd0 ? RF_LB : f3 == 3'd1 ? RF_LH : f3 == 3'd4 ? RF_LBU :
                           f3 == 3'd5 ? RF_LHU : RF_LW;
        w.trap = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        w.mem_write = 1'b1; w.alumux2_sel = A2_S_IMM; w.aluop = ALU_ADD; w.trap = f3 >= 3'd3;
      end
      OP_IMM, OP_REG: begin
        w.load_regfile = 1'b1;
        w.alumux2_sel = op == OP_REG ? A2_RS2 : A2_I_IMM;
        if (mext) w.trap = ~M_EN;
        else begin
          if (slt) begin
            w.cmpop = f3[0] ? CMP_BLTU : CMP_BLT;
            w.cmpmux_sel = op == OP_IMM ? CMP_I_IMM : CMP_RS2;
            w.regfilemux_sel = RF_BR_EN;
          end
          if (f3 == 3'd5) w.aluop = f7[5] ? ALU_SRA : ALU_SRL;
          if (f3 == 3'd0 && op == OP_REG) w.aluop = f7[5] ? ALU_SUB : ALU_ADD;
          w.trap = shift && f7 != 7'h00 && f7 != 7'h20;
        end
      end
      default: w.trap = 1'b1;
    endcase
  end
  always_comb begin
    m = '0;
    m.trap = w.trap;
    m.commit = ~w.trap & (w.load_regfile | w.br | w.mem_write);
    m.rd_addr = bus.in_instr[11:7];
    m.insn = bus.in_instr;
    m.pc_rdata = bus.in_pc;
    m.pc_wdata = bus.in_pc + 32'd4;
  end
  // a full queue still accepts when the head leaves in the same cycle
  assign bus.in_ready = state == RUN && !bus.flush && (count != FULL || bus.out_ready);
  assign bus.out_valid = count != '0;
  assign bus.halted = state == HALT;
  assign bus.out_word = bus.out_valid ? mem[head].word : '0;
  assign bus.out_monitor = bus.out_valid ? mem[head].mon : '0;
  assign bus.out_order = order;
  assign push = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  always_comb state_n = bus.flush ? RUN : (push && w.trap) ? HALT : state;
  always_ff @(posedge clk) state <= rst ? RUN : state_n;
  always_ff @(posedge clk) if (push) mem[tail] <= '{w, m};
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail == LAST ? '0 : tail + 1'b1;
      if (pop) head <= head == LAST ? '0 : head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
    if (rst) order <= '0;
    else if (pop && !bus.flush && mem[head].mon.commit) order <= order + 1'b1;
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: randomized scoreboard bench for decode_queue against a rule-level decode/queue model
module tb_decode_queue;
  import decode_queue_pkg::*;
  localparam int D = 2;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  typedef struct packed {
    rv32i_control_word w;
    monitor_t          m;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decode_queue_if #(.XLEN(32), .ORDER_W(64)) bus();
  decode_queue #(.XLEN(32), .BUF_DEPTH(D), .ORDER_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          run = 1'b1;
  logic [63:0] exp_order = '0;
  bit          started = 1'b0;
  bit          pend_push = 1'b0, pend_flush = 1'b0, pend_rst = 1'b0;
  exp_t        pend_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit legal, m_op, sh;
    e = '0;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    m_op = op == OP_REG && f7 == 7'h01;
    sh = f3 inside {3'd1, 3'd5};
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
      OP_BR:    legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      OP_LOAD:  legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      OP_STORE: legal = f3 inside {3'd0, 3'd1, 3'd2};
      OP_IMM:   legal = !sh || f7 inside {7'h00, 7'h20};
      OP_REG:   legal = m_op ? M_EN : (!sh || f7 inside {7'h00, 7'h20});
      default:  legal = 1'b0;
    endcase
    e.w.opcode = op;
    e.w.rd = ins[11:7];
    e.w.funct3 = f3;
    e.w.funct7 = f7;
    e.w.trap = !legal;
    e.w.aluop = op inside {OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE} ? ALU_ADD : f3;
    e.w.load_regfile = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
    e.w.br = op == OP_BR;
    e.w.mem_read = op == OP_LOAD;
    e.w.mem_write = op == OP_STORE;
    e.w.alumux1_sel = op inside {OP_AUIPC, OP_JAL, OP_BR} ? A1_PC : A1_RS1;
    e.w.alumux2_sel = op == OP_AUIPC ? A2_U_IMM : op == OP_JAL ? A2_J_IMM : op == OP_BR ? A2_B_IMM :
                      op == OP_STORE ? A2_S_IMM : op == OP_REG ? A2_RS2 : A2_I_IMM;
    e.w.pcmux_sel = op == OP_JAL ? PC_ALU_OUT : op == OP_JALR ? PC_ALU_MOD2 : PC_PLUS4;
    if (op == OP_BR) e.w.cmpop = f3;
    if (op == OP_LUI) e.w.regfilemux_sel = RF_U_IMM;
    if (op inside {OP_JAL, OP_JALR}) e.w.regfilemux_sel = RF_PC_PLUS4;
    if (op == OP_LOAD)
      case (f3)
        3'd0: e.w.regfilemux_sel = RF_LB;
        3'd1: e.w.regfilemux_sel = RF_LH;
        3'd4: e.w.regfilemux_sel = RF_LBU;
        3'd5: e.w.regfilemux_sel = RF_LHU;
        default: e.w.regfilemux_sel = RF_LW;
      endcase
    if (op inside {OP_IMM, OP_REG} && !m_op) begin
      if (f3 == 3'd2 || f3 == 3'd3) begin
        e.w.cmpop = f3 == 3'd2 ? CMP_BLT : CMP_BLTU;
        e.w.cmpmux_sel = op == OP_IMM ? CMP_I_IMM : CMP_RS2;
        e.w.regfilemux_sel = RF_BR_EN;
      end
      if (f3 == 3'd5) e.w.aluop = f7[5] ? ALU_SRA : ALU_SRL;
      if (op == OP_REG && f3 == 3'd0 && f7[5]) e.w.aluop = ALU_SUB;
    end
    e.m.trap = !legal;
    e.m.commit = legal && (e.w.load_regfile || e.w.br || e.w.mem_write);
    e.m.rd_addr = ins[11:7];
    e.m.insn = ins;
    e.m.pc_rdata = pc;
    e.m.pc_wdata = pc + 32'd4;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0] brf [6];
    logic [2:0] ldf [5];
    int k;
    brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    r = $urandom;
    k = $urandom_range(0, 31);
    case (k)
      0: r[6:0] = OP_LUI;
      1: r[6:0] = OP_AUIPC;
      2: r[6:0] = OP_JAL;
      3: r[6:0] = OP_JALR;
      4, 5: begin r[6:0] = OP_BR; r[14:12] = brf[$urandom_range(0, 5)]; end
      6, 7: begin r[6:0] = OP_LOAD; r[14:12] = ldf[$urandom_range(0, 4)]; end
      8: begin r[6:0] = OP_STORE; r[14:12] = 3'($urandom_range(0, 2)); end
      9, 10, 11, 12, 13, 14, 15, 16: begin
        r[6:0] = OP_IMM;
        if (r[14:12] == 3'd1) r[31:25] = 7'h00;
        if (r[14:12] == 3'd5) r[31:25] = r[20] ? 7'h20 : 7'h00;
      end
      17, 18, 19, 20, 21, 22, 23, 24, 25, 26: begin
        r[6:0] = OP_REG;
        r[31:25] = (r[14:12] inside {3'd0, 3'd5} && r[20]) ? 7'h20 : 7'h00;
      end
      27: r = r[0] ? {7'h01, r[24:7], OP_REG} : r;
      default: r[14:0] = {3'd0, r[11:7], OP_IMM};
    endcase
    return r;
  endfunction

  // expected state after the edge is committed first, then the next cycle's inputs are driven and predicted
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl, input bit r);
    bit pred_ready;
    @(posedge clk);
    if (pend_rst || pend_flush) begin
      exp_q.delete();
      run = 1'b1;
    end else if (pend_push) begin
      exp_q.push_back(pend_e);
      if (pend_e.w.trap) run = 1'b0;
    end
    #1;
    rst = r;
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.out_ready = rdy;
    bus.flush = fl;
    #1;
    pred_ready = run && !fl && (exp_q.size() < D || rdy);
    chk("in_ready", bus.in_ready, pred_ready);
    chk("halted", bus.halted, !run);
    pend_push = v && pred_ready && !r;
    pend_flush = fl;
    pend_rst = r;
    pend_e = model(ins, pc);
  endtask

  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      chk("out_order", bus.out_order, exp_order);
      if (exp_q.size() != 0) begin
        chk("out_word", bus.out_word, exp_q[0].w);
        chk("out_monitor", bus.out_monitor, exp_q[0].m);
        if (bus.out_ready) begin
          if (!bus.flush && !rst && exp_q[0].m.commit) exp_order++;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_word", bus.out_word, '0);
        chk("idle_monitor", bus.out_monitor, '0);
      end
      if (rst) exp_order = '0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1);
  end

  localparam logic [31:0] ADDI = 32'h00500093, ADD = 32'h002081B3, MUL = 32'h022081B3;
  initial begin
    bit fl, r, v, rdy;
    logic [31:0] pc;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    started = 1'b1;
    step(1, ADDI, 32'h60000000, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, ADD, 32'h60000004, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 32'h00100113, 32'h100, 0, 0, 0);
    step(1, 32'h00200193, 32'h104, 0, 0, 0);
    step(1, 32'h00300213, 32'h108, 0, 0, 0);
    step(1, 32'h00300213, 32'h108, 0, 0, 0);
    step(1, 32'h00300213, 32'h108, 1, 0, 0);
    step(1, 32'h00400293, 32'h10C, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(1, 32'h00000000, 32'h200, 0, 0, 0);
    step(1, ADD, 32'h204, 0, 0, 0);
    step(1, ADD, 32'h204, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, ADD, 32'h300, 0, 0, 0);
    step(1, ADDI, 32'h304, 0, 0, 0);
    step(1, ADD, 32'h308, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, MUL, 32'hFFFFFFFC, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, ADD, 32'h400, 0, 0, 0);
    step(1, 32'h00000000, 32'h404, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      fl = run ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 299) == 0;
      v = $urandom_range(0, 9) < 7;
      rdy = $urandom_range(0, 9) < 6;
      pc = $urandom_range(0, 15) == 0 ? 32'hFFFFFFFC : $urandom;
      step(v, rand_instr(), pc, rdy, fl, r);
    end
    repeat (4) step(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
